// File: rtl/keypad_scanner.sv
// keypad_scanner
//   Scans a 4x4 active-low matrix keypad one row at a time. It returns one debounced 4-bit
//   key code per press, together with a single-cycle strobe, so the counter/seven-segment
//   path can consume key values directly. Contact bounce is filtered on both press and
//   release. While a key is held, every other key is ignored.
//
// Parameters
//   SCAN_DIV      clk cycles spent on each row (one tick per row period), >= 4
//   DEBOUNCE_CNT  consecutive matching ticks needed to accept a press or a release, >= 1
//
// Ports
//   clk          system clock, rising edge
//   rst_a        asynchronous reset, active-high
//   cols         keypad columns, active-low, asynchronous to clk
//   rows         keypad row drive, active-low one-hot
//   key_code     last accepted key = {row index, column index}
//   key_valid    one-cycle pulse when a debounced press is accepted
//   key_pressed  high from acceptance until a debounced release

module keypad_scanner #(
   parameter int SCAN_DIV     = 1000,
   parameter int DEBOUNCE_CNT = 10
) (
   input  logic       clk,
   input  logic       rst_a,
   input  logic [3:0] cols,
   output logic [3:0] rows,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_pressed
);

   localparam int TimerW = $clog2(SCAN_DIV);
   localparam int CntW   = $clog2(DEBOUNCE_CNT + 1);
   localparam logic [TimerW-1:0] TimerMax = TimerW'(SCAN_DIV - 1);
   localparam logic [CntW-1:0]   CntMax   = CntW'(DEBOUNCE_CNT);

   typedef enum logic [1:0] {
      SCAN,
      DEBOUNCE,
      HELD
   } state_t;

   state_t            state_q, state_d;
   logic [3:0]        colsMeta_q, colsSync_q;
   logic [TimerW-1:0] timer_q;
   logic [1:0]        rowIdx_q, rowIdx_d;
   logic [1:0]        candCol_q, candCol_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [3:0]        keyCode_q, keyCode_d;
   logic              keyValid_q, keyValid_d;
   logic              keyPressed_q, keyPressed_d;

   logic              tick;
   logic              anyLow;
   logic              candLow;
   logic [1:0]        pickCol;
   logic [CntW-1:0]   cntInc;
   logic              cntHit;

   // The columns are asynchronous keypad contacts. They pass through two flops before any
   // logic looks at them. They are only sampled on a tick, which is far later than the
   // two-cycle delay, so the synchronized value has always settled for the current row.
   always_ff @(posedge clk or posedge rst_a) begin
      if (rst_a) begin
         colsMeta_q <= 4'b0000;
         colsSync_q <= 4'b0000;
      end else begin
         colsMeta_q <= cols;
         colsSync_q <= colsMeta_q;
      end
   end

   // The row timer runs freely in every state. Its last count marks the tick on which all
   // scanning and debounce decisions are taken.
   always_ff @(posedge clk or posedge rst_a) begin
      if (rst_a) begin
         timer_q <= '0;
      end else if (tick) begin
         timer_q <= '0;
      end else begin
         timer_q <= timer_q + TimerW'(1);
      end
   end

   assign tick    = (timer_q == TimerMax);
   assign anyLow  = ~&colsSync_q;
   assign candLow = ~colsSync_q[candCol_q];
   assign cntInc  = (cnt_q == CntMax) ? cnt_q : cnt_q + CntW'(1);
   assign cntHit  = (cntInc == CntMax);

   // When several keys in the scanned row are down, the lowest column wins and the others
   // are ignored. This keeps a multi-key press deterministic.
   always_comb begin
      pickCol = 2'd3;
      if (!colsSync_q[0]) begin
         pickCol = 2'd0;
      end else if (!colsSync_q[1]) begin
         pickCol = 2'd1;
      end else if (!colsSync_q[2]) begin
         pickCol = 2'd2;
      end
   end

   // State register for the scan/debounce FSM and everything it owns. Each of these
   // registers changes only through the next-state logic below.
   always_ff @(posedge clk or posedge rst_a) begin
      if (rst_a) begin
         state_q      <= SCAN;
         rowIdx_q     <= 2'd0;
         candCol_q    <= 2'd0;
         cnt_q        <= '0;
         keyCode_q    <= 4'd0;
         keyValid_q   <= 1'b0;
         keyPressed_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         rowIdx_q     <= rowIdx_d;
         candCol_q    <= candCol_d;
         cnt_q        <= cnt_d;
         keyCode_q    <= keyCode_d;
         keyValid_q   <= keyValid_d;
         keyPressed_q <= keyPressed_d;
      end
   end

   // Next-state logic. Every decision waits for a tick. The row index only moves while
   // scanning, so the row stays on the candidate key during debounce and hold. A failed
   // debounce returns to scanning and rotation resumes from the candidate row on the
   // following tick. key_valid defaults low, so an acceptance gives exactly one pulse.
   always_comb begin
      state_d      = state_q;
      rowIdx_d     = rowIdx_q;
      candCol_d    = candCol_q;
      cnt_d        = cnt_q;
      keyCode_d    = keyCode_q;
      keyValid_d   = 1'b0;
      keyPressed_d = keyPressed_q;
      if (tick) begin
         case (state_q)
            SCAN: begin
               if (anyLow) begin
                  candCol_d = pickCol;
                  cnt_d     = '0;
                  state_d   = DEBOUNCE;
               end else begin
                  rowIdx_d = rowIdx_q + 2'd1;
               end
            end
            DEBOUNCE: begin
               if (candLow) begin
                  if (cntHit) begin
                     keyCode_d    = {rowIdx_q, candCol_q};
                     keyValid_d   = 1'b1;
                     keyPressed_d = 1'b1;
                     cnt_d        = '0;
                     state_d      = HELD;
                  end else begin
                     cnt_d = cntInc;
                  end
               end else begin
                  cnt_d   = '0;
                  state_d = SCAN;
               end
            end
            HELD: begin
               if (!candLow) begin
                  if (cntHit) begin
                     keyPressed_d = 1'b0;
                     cnt_d        = '0;
                     state_d      = SCAN;
                  end else begin
                     cnt_d = cntInc;
                  end
               end else begin
                  cnt_d = '0;
               end
            end
            default: begin
               state_d = SCAN;
            end
         endcase
      end
   end

   assign rows        = ~(4'b0001 << rowIdx_q);
   assign key_code    = keyCode_q;
   assign key_valid   = keyValid_q;
   assign key_pressed = keyPressed_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner
//   Directed bench for keypad_scanner with SCAN_DIV=4 and DEBOUNCE_CNT=3. A small keypad
//   model pulls a column low when a pressed key sits on the driven row. cyc counts rising
//   edges since the last reset release. Every expected value below is a hand-computed
//   cycle number or output value.

module tb_keypad_scanner;

   localparam int SCAN_DIV     = 4;
   localparam int DEBOUNCE_CNT = 3;

   logic        clk;
   logic        rstA;
   logic [3:0]  cols;
   logic [3:0]  rows;
   logic [3:0]  keyCode;
   logic        keyValid;
   logic        keyPressed;

   logic [15:0] keys;
   int          cyc;
   int          vectors     = 0;
   int          miscompares = 0;
   int          validCount  = 0;
   int          doubleCount = 0;
   logic        prevValid   = 1'b0;

   keypad_scanner #(
      .SCAN_DIV    (SCAN_DIV),
      .DEBOUNCE_CNT(DEBOUNCE_CNT)
   ) dut (
      .clk        (clk),
      .rst_a      (rstA),
      .cols       (cols),
      .rows       (rows),
      .key_code   (keyCode),
      .key_valid  (keyValid),
      .key_pressed(keyPressed)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Keypad matrix: a column reads low when any pressed key in it is on a driven row.
   always_comb begin
      cols = 4'b1111;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (keys[r*4+c] && !rows[r]) begin
               cols[c] = 1'b0;
            end
         end
      end
   end

   // Rising-edge count since reset was last released; the DUT row timer tracks it mod 4.
   always @(posedge clk or posedge rstA) begin
      if (rstA) begin
         cyc <= 0;
      end else begin
         cyc <= cyc + 1;
      end
   end

   // Count every key_valid pulse and any back-to-back high cycles.
   always @(negedge clk) begin
      if (keyValid) begin
         validCount++;
      end
      if (keyValid && prevValid) begin
         doubleCount++;
      end
      prevValid = keyValid;
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input int r, input int c, input logic down);
      keys[r*4+c] = down;
   endtask

   task automatic waitCyc(input int n);
      while (cyc < n) @(negedge clk);
   endtask

   initial begin
      rstA = 1'b1;
      keys = 16'h0000;
      @(negedge clk);
      rstA = 1'b0;

      // Reset asserted mid-cycle after the rows have started moving
      waitCyc(6);
      checkOutput("pre_reset_rows", rows, 4'b1101);
      rstA = 1'b1;
      #1;
      checkOutput("rst_rows", rows, 4'b1110);
      checkOutput("rst_code", keyCode, 4'd0);
      checkOutput("rst_valid", keyValid, 1'b0);
      checkOutput("rst_pressed", keyPressed, 1'b0);
      @(negedge clk);
      rstA = 1'b0;

      // Row rotation every 4 clocks
      waitCyc(2);  checkOutput("rot_r0", rows, 4'b1110);
      waitCyc(6);  checkOutput("rot_r1", rows, 4'b1101);
      waitCyc(10); checkOutput("rot_r2", rows, 4'b1011);
      waitCyc(14); checkOutput("rot_r3", rows, 4'b0111);
      waitCyc(18); checkOutput("rot_wrap", rows, 4'b1110);

      // Clean press of (2,1): detected on tick 28, accepted on tick 40
      applyStimulus(2, 1, 1'b1);
      waitCyc(39); checkOutput("p21_early", keyValid, 1'b0);
      waitCyc(40);
      checkOutput("p21_valid", keyValid, 1'b1);
      checkOutput("p21_code", keyCode, 4'd9);
      checkOutput("p21_pressed", keyPressed, 1'b1);
      waitCyc(41); checkOutput("p21_one_cycle", keyValid, 1'b0);
      waitCyc(60);
      checkOutput("p21_row_held", rows, 4'b1011);
      checkOutput("p21_still_pressed", keyPressed, 1'b1);
      checkOutput("p21_no_repeat", validCount, 1);

      // Release with a one-tick re-close at tick 72 that restarts the release count
      applyStimulus(2, 1, 1'b0);
      waitCyc(68); applyStimulus(2, 1, 1'b1);
      waitCyc(72); applyStimulus(2, 1, 1'b0);
      waitCyc(76); checkOutput("rel_restart", keyPressed, 1'b1);
      waitCyc(83); checkOutput("rel_before", keyPressed, 1'b1);
      waitCyc(84);
      checkOutput("rel_done", keyPressed, 1'b0);
      checkOutput("rel_no_valid", validCount, 1);

      // Bounce of (1,3): detected on tick 100 only, dropped on tick 104
      waitCyc(85);  applyStimulus(1, 3, 1'b1);
      waitCyc(100); applyStimulus(1, 3, 1'b0);
      waitCyc(103); checkOutput("bnc_row_hold", rows, 4'b1101);
      waitCyc(106); checkOutput("bnc_row_stay", rows, 4'b1101);
      waitCyc(109); checkOutput("bnc_row_resume", rows, 4'b1011);
      waitCyc(130);
      checkOutput("bnc_no_valid", validCount, 1);
      checkOutput("bnc_code_kept", keyCode, 4'd9);
      checkOutput("bnc_not_pressed", keyPressed, 1'b0);

      // (3,0)+(3,3) together: lowest column wins, detected on tick 148, accepted on tick 160
      waitCyc(133);
      applyStimulus(3, 0, 1'b1);
      applyStimulus(3, 3, 1'b1);
      waitCyc(159); checkOutput("multi_early", keyValid, 1'b0);
      waitCyc(160);
      checkOutput("multi_valid", keyValid, 1'b1);
      checkOutput("multi_code", keyCode, 4'd12);
      checkOutput("multi_pressed", keyPressed, 1'b1);

      // (0,2) pressed while HELD is ignored until the release is accepted on tick 192
      waitCyc(165); applyStimulus(0, 2, 1'b1);
      waitCyc(179);
      checkOutput("held_ignore_cnt", validCount, 2);
      checkOutput("held_ignore_code", keyCode, 4'd12);
      checkOutput("held_row", rows, 4'b0111);
      waitCyc(180);
      applyStimulus(3, 0, 1'b0);
      applyStimulus(3, 3, 1'b0);
      waitCyc(191); checkOutput("multi_rel_before", keyPressed, 1'b1);
      waitCyc(192); checkOutput("multi_rel_done", keyPressed, 1'b0);
      waitCyc(211);
      checkOutput("p02_early", keyValid, 1'b0);
      checkOutput("p02_code_kept", keyCode, 4'd12);
      waitCyc(212);
      checkOutput("p02_valid", keyValid, 1'b1);
      checkOutput("p02_code", keyCode, 4'd2);

      // Reset while HELD with (0,2) still down: cleared at once, then re-accepted
      waitCyc(219);
      checkOutput("held_before_rst", keyPressed, 1'b1);
      rstA = 1'b1;
      #1;
      checkOutput("rstH_rows", rows, 4'b1110);
      checkOutput("rstH_code", keyCode, 4'd0);
      checkOutput("rstH_valid", keyValid, 1'b0);
      checkOutput("rstH_pressed", keyPressed, 1'b0);
      @(negedge clk);
      rstA = 1'b0;
      waitCyc(15); checkOutput("reacc_early", keyValid, 1'b0);
      waitCyc(16);
      checkOutput("reacc_valid", keyValid, 1'b1);
      checkOutput("reacc_code", keyCode, 4'd2);
      waitCyc(17); applyStimulus(0, 2, 1'b0);
      waitCyc(27); checkOutput("reacc_rel_before", keyPressed, 1'b1);
      waitCyc(28); checkOutput("reacc_rel_done", keyPressed, 1'b0);

      // Reset while in DEBOUNCE on (1,0), with the key released during reset
      waitCyc(29); applyStimulus(1, 0, 1'b1);
      waitCyc(37); checkOutput("deb_row_hold", rows, 4'b1101);
      waitCyc(38);
      rstA = 1'b1;
      #1;
      checkOutput("rstD_rows", rows, 4'b1110);
      checkOutput("rstD_code", keyCode, 4'd0);
      checkOutput("rstD_valid", keyValid, 1'b0);
      checkOutput("rstD_pressed", keyPressed, 1'b0);
      keys = 16'h0000;
      @(negedge clk);
      rstA = 1'b0;
      waitCyc(80);
      checkOutput("final_valid_count", validCount, 4);
      checkOutput("final_no_double", doubleCount, 0);
      checkOutput("final_pressed", keyPressed, 1'b0);
      checkOutput("final_code", keyCode, 4'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
